// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
// fetch_entry_t is one prefetch slot: the fetched word tagged with its byte PC.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned WORD_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer, DEPTH entries of entry_t; head is registered storage, one-cycle write-to-head.
// Push while full is dropped unless a pop happens the same cycle; flush wins over push and pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type entry_t = logic [63:0]
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   flush,
  input  entry_t wdata,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)
        count_q <= count_q + (PW+1)'(1);
      else if (do_pop && !do_push)
        count_q <= count_q - (PW+1)'(1);
    end
  end

  // Full with simultaneous pop writes the slot being read; the read completes before the edge.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: PC, async ROM addressing, prefetch FIFO; ROM word reaches the head one cycle later.
// Stalls fetch when the FIFO is full and not draining; optional FETCH_CTRL_PERF_EN adds perf counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] FETCH_LIMIT = 32'(IMEM_WORDS * WORD_BYTES);

  logic [31:0]  pc_q;
  logic [31:0]  pc_d;
  logic         push;
  logic         pop;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t wr_entry;
  fetch_entry_t head_entry;
  logic         unused_redirect_bits;

  assign imem_addr   = pc_q;
  assign fetch_fault = (pc_q >= FETCH_LIMIT);
  assign instr_valid = ~fifo_empty;
  assign instr       = head_entry.instr;
  assign instr_pc    = head_entry.pc;
  assign pop         = instr_valid & instr_ready;
  assign push        = ~redirect & ~fetch_fault & (~fifo_full | pop);

  assign wr_entry.pc    = pc_q;
  assign wr_entry.instr = imem_instr;

  // Redirect targets are forced word aligned.
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_comb begin
    pc_d = pc_q;
    if (redirect)
      pc_d = {redirect_pc[31:2], 2'b00};
    else if (push)
      pc_d = pc_q + WORD_BYTES;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (wr_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_entry)
  );

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && (perf_fetch_q != '1))
        perf_fetch_q <= perf_fetch_q + 32'd1;
      if (instr_valid && !instr_ready && (perf_stall_q != '1))
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
